run_controller: RTL and testbench

//  Sequences the single-cycle processor from outside: boots it, then runs, single-steps,

---
 rtl/run_controller.sv | 127 ++++++++++++
 tb/tb_run_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run controller that boots, runs, single-steps and stops the single-cycle processor.
// It also detects the HALT opcode and enforces a watchdog on executed cycles.
module run_controller #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        step,
    input  logic        halt_req,
    input  logic [31:0] instruction,
    output logic        start_up,
    output logic        cpu_en,
    output logic [2:0]  state,
    output logic [31:0] cycle_count,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_IDLE    = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_HALT    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    // A BOOT_CYCLES of 0 is treated as 1 so that BOOT always lasts at least one cycle.
    localparam logic [31:0] BOOT_LAST = (BOOT_CYCLES > 1) ? 32'(BOOT_CYCLES - 1) : 32'd0;
    localparam logic [31:0] MAX_CNT   = 32'(MAX_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] boot_cnt_q, boot_cnt_d;
    logic [31:0] cycle_q, cycle_d;
    logic        is_halt;
    logic        wd_hit;
    logic        in_run;
    logic        unused_instr;

    assign unused_instr = ^instruction[25:0];
    assign is_halt      = (instruction[31:26] == HALT_OPCODE);
    assign wd_hit       = (MAX_CYCLES != 0) && (cycle_q == MAX_CNT);
    assign in_run       = (state_q == S_RUN);
    assign cpu_en       = (in_run || (state_q == S_STEP)) && !is_halt && !wd_hit
                          && !(in_run && halt_req);

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        cycle_d    = cycle_q;

        // Saturate rather than wrap when the watchdog is disabled.
        if (cpu_en && (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_d = cycle_q + 32'd1;
        end

        case (state_q)
            S_BOOT: begin
                if (boot_cnt_q >= BOOT_LAST) begin
                    state_d    = S_IDLE;
                    boot_cnt_d = 32'd0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
                if (go) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (wd_hit) begin
                    state_d = S_TIMEOUT;
                end else if (halt_req) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (wd_hit) begin
                    state_d = S_TIMEOUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT, S_TIMEOUT: begin
                if (go) begin
                    state_d    = S_BOOT;
                    boot_cnt_d = 32'd0;
                    cycle_d    = 32'd0;
                end
            end
            default: begin
                state_d    = S_BOOT;
                boot_cnt_d = 32'd0;
                cycle_d    = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= 32'd0;
            cycle_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            cycle_q    <= cycle_d;
        end
    end

    assign state       = state_q;
    assign cycle_count = cycle_q;
    assign start_up    = (state_q == S_BOOT);
    assign done        = (state_q == S_HALT) || (state_q == S_TIMEOUT);
    assign timeout     = (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: boot, run-to-halt, stepping, watchdog, pause/resume, reset.
module tb_run_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] instruction;
    logic        start_up, cpu_en, done, timeout;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    // {start_up, cpu_en, state[2:0], done, timeout}
    localparam logic [6:0] E_BOOT    = 7'b1_0_000_0_0;
    localparam logic [6:0] E_IDLE    = 7'b0_0_001_0_0;
    localparam logic [6:0] E_RUN_EN  = 7'b0_1_010_0_0;
    localparam logic [6:0] E_RUN_NO  = 7'b0_0_010_0_0;
    localparam logic [6:0] E_STEP_EN = 7'b0_1_011_0_0;
    localparam logic [6:0] E_STEP_NO = 7'b0_0_011_0_0;
    localparam logic [6:0] E_HALT    = 7'b0_0_100_1_0;
    localparam logic [6:0] E_TMO     = 7'b0_0_101_1_1;

    wire [6:0] obs = {start_up, cpu_en, state, done, timeout};

    always #5 clk = ~clk;

    run_controller #(
        .BOOT_CYCLES(2),
        .MAX_CYCLES (8),
        .HALT_OPCODE(6'h3F)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .step       (step),
        .halt_req   (halt_req),
        .instruction(instruction),
        .start_up   (start_up),
        .cpu_en     (cpu_en),
        .state      (state),
        .cycle_count(cycle_count),
        .done       (done),
        .timeout    (timeout)
    );

    // Reset, release and wait until the controller has passed through BOOT into IDLE.
    task automatic do_boot();
        @(negedge clk);
        rst_n = 1'b0; go = 1'b0; step = 1'b0; halt_req = 1'b0; instruction = NOP;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        instruction = NOP;
        @(negedge clk); #1;
        total++; if (obs !== E_BOOT) begin bad++; $display("FAIL rst_obs: got %b want %b", obs, E_BOOT); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", cycle_count); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (obs !== E_BOOT) begin bad++; $display("FAIL boot_cycle2: got %b want %b", obs, E_BOOT); end
        @(negedge clk); #1;
        total++; if (obs !== E_IDLE) begin bad++; $display("FAIL boot_to_idle: got %b want %b", obs, E_IDLE); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL boot_cnt: got %0d want 0", cycle_count); end
    endtask

    task automatic test_run_halt();
        @(negedge clk); go = 1'b1; #1;
        total++; if (obs !== E_IDLE) begin bad++; $display("FAIL go_latency: got %b want %b", obs, E_IDLE); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); go = 1'b0; #1;
            total++; if (obs !== E_RUN_EN) begin bad++; $display("FAIL run_en[%0d]: got %b want %b", i, obs, E_RUN_EN); end
            total++; if (cycle_count !== 32'(i)) begin bad++; $display("FAIL run_cnt[%0d]: got %0d want %0d", i, cycle_count, i); end
        end
        @(negedge clk); instruction = HALT; #1;
        total++; if (obs !== E_RUN_NO) begin bad++; $display("FAIL halt_cycle: got %b want %b", obs, E_RUN_NO); end
        @(negedge clk); step = 1'b1; #1;
        total++; if (obs !== E_HALT) begin bad++; $display("FAIL halt_state: got %b want %b", obs, E_HALT); end
        total++; if (cycle_count !== 32'd5) begin bad++; $display("FAIL halt_cnt: got %0d want 5", cycle_count); end
        @(negedge clk); step = 1'b0; #1;
        total++; if (obs !== E_HALT) begin bad++; $display("FAIL halt_step_ignored: got %b want %b", obs, E_HALT); end
        @(negedge clk); go = 1'b1; instruction = NOP; #1;
        @(negedge clk); go = 1'b0; #1;
        total++; if (obs !== E_BOOT) begin bad++; $display("FAIL restart_boot: got %b want %b", obs, E_BOOT); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL restart_cnt: got %0d want 0", cycle_count); end
        @(negedge clk); #1;
        total++; if (obs !== E_BOOT) begin bad++; $display("FAIL restart_boot2: got %b want %b", obs, E_BOOT); end
        @(negedge clk); #1;
        total++; if (obs !== E_IDLE) begin bad++; $display("FAIL restart_idle: got %b want %b", obs, E_IDLE); end
    endtask

    task automatic test_step();
        int en_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); step = 1'b1; #1;
            en_seen += int'(cpu_en);
            total++; if (obs !== E_IDLE) begin bad++; $display("FAIL step_req[%0d]: got %b want %b", k, obs, E_IDLE); end
            // halt_req on the last step must not suppress the commit
            @(negedge clk); step = 1'b0; halt_req = (k == 2); #1;
            en_seen += int'(cpu_en);
            total++; if (obs !== E_STEP_EN) begin bad++; $display("FAIL step_exec[%0d]: got %b want %b", k, obs, E_STEP_EN); end
            @(negedge clk); halt_req = 1'b0; #1;
            en_seen += int'(cpu_en);
            total++; if (obs !== E_IDLE) begin bad++; $display("FAIL step_back[%0d]: got %b want %b", k, obs, E_IDLE); end
            total++; if (cycle_count !== 32'(k + 1)) begin bad++; $display("FAIL step_cnt[%0d]: got %0d want %0d", k, cycle_count, k + 1); end
        end
        total++; if (en_seen !== 3) begin bad++; $display("FAIL step_en_total: got %0d want 3", en_seen); end
    endtask

    task automatic test_step_halt();
        @(negedge clk); step = 1'b1; instruction = HALT; #1;
        @(negedge clk); step = 1'b0; #1;
        total++; if (obs !== E_STEP_NO) begin bad++; $display("FAIL step_on_halt: got %b want %b", obs, E_STEP_NO); end
        @(negedge clk); #1;
        total++; if (obs !== E_HALT) begin bad++; $display("FAIL step_to_halt: got %b want %b", obs, E_HALT); end
        total++; if (cycle_count !== 32'd3) begin bad++; $display("FAIL step_halt_cnt: got %0d want 3", cycle_count); end
    endtask

    task automatic test_timeout();
        do_boot();
        go = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); go = 1'b0; #1;
            total++; if (obs !== E_RUN_EN) begin bad++; $display("FAIL wd_run[%0d]: got %b want %b", i, obs, E_RUN_EN); end
        end
        @(negedge clk); #1;
        total++; if (obs !== E_RUN_NO) begin bad++; $display("FAIL wd_hit_cycle: got %b want %b", obs, E_RUN_NO); end
        @(negedge clk); step = 1'b1; halt_req = 1'b1; #1;
        total++; if (obs !== E_TMO) begin bad++; $display("FAIL wd_state: got %b want %b", obs, E_TMO); end
        total++; if (cycle_count !== 32'd8) begin bad++; $display("FAIL wd_cnt: got %0d want 8", cycle_count); end
        @(negedge clk); step = 1'b0; halt_req = 1'b0; go = 1'b1; #1;
        total++; if (obs !== E_TMO) begin bad++; $display("FAIL wd_sticky: got %b want %b", obs, E_TMO); end
        @(negedge clk); go = 1'b0; #1;
        total++; if (obs !== E_BOOT) begin bad++; $display("FAIL wd_restart: got %b want %b", obs, E_BOOT); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL wd_restart_cnt: got %0d want 0", cycle_count); end
    endtask

    task automatic test_halt_req();
        do_boot();
        go = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); go = 1'b0; #1;
        end
        @(negedge clk); halt_req = 1'b1; #1;
        total++; if (obs !== E_RUN_NO) begin bad++; $display("FAIL pause_cycle: got %b want %b", obs, E_RUN_NO); end
        total++; if (cycle_count !== 32'd4) begin bad++; $display("FAIL pause_cnt: got %0d want 4", cycle_count); end
        @(negedge clk); halt_req = 1'b0; go = 1'b1; #1;
        total++; if (obs !== E_IDLE) begin bad++; $display("FAIL pause_idle: got %b want %b", obs, E_IDLE); end
        for (int i = 4; i < 8; i++) begin
            @(negedge clk); go = 1'b0; #1;
            total++; if (cycle_count !== 32'(i) || !cpu_en) begin bad++; $display("FAIL resume_cnt[%0d]: got %0d en=%b want %0d en=1", i, cycle_count, cpu_en, i); end
        end
        // HALT opcode, watchdog limit and halt_req all present: HALT must win
        @(negedge clk); instruction = HALT; halt_req = 1'b1; #1;
        total++; if (obs !== E_RUN_NO) begin bad++; $display("FAIL prio_cycle: got %b want %b", obs, E_RUN_NO); end
        @(negedge clk); halt_req = 1'b0; #1;
        total++; if (obs !== E_HALT) begin bad++; $display("FAIL prio_halt: got %b want %b", obs, E_HALT); end
    endtask

    task automatic test_reset_mid_run();
        do_boot();
        go = 1'b1; step = 1'b1; #1;
        @(negedge clk); go = 1'b0; step = 1'b0; #1;
        total++; if (obs !== E_RUN_EN) begin bad++; $display("FAIL go_step_both: got %b want %b", obs, E_RUN_EN); end
        @(negedge clk); #1;
        total++; if (cycle_count !== 32'd1) begin bad++; $display("FAIL mid_cnt: got %0d want 1", cycle_count); end
        #2 rst_n = 1'b0; #1;
        total++; if (obs !== E_BOOT) begin bad++; $display("FAIL async_rst_obs: got %b want %b", obs, E_BOOT); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL async_rst_cnt: got %0d want 0", cycle_count); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (obs !== E_BOOT) begin bad++; $display("FAIL reboot: got %b want %b", obs, E_BOOT); end
        @(negedge clk); #1;
        total++; if (obs !== E_IDLE) begin bad++; $display("FAIL reboot_idle: got %b want %b", obs, E_IDLE); end
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no finish want finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_run_halt();
        test_step();
        test_step_halt();
        test_timeout();
        test_halt_req();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
